// File: rtl/tt_um_monishvr_fifo.sv
`default_nettype none
// tt_um_monishvr_fifo: single-clock DEPTH x DATA_W FIFO tile, occupancy shown on uio_out.
// Revision: 1.0 - initial release
module tt_um_monishvr_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] dout;

  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic              empty;
  logic              full;
  logic              rd_ok;
  logic              wr_ok;
  logic              unused;

  assign din   = ui_in[DATA_W-1:0];
  assign wr_en = ui_in[6];
  assign rd_en = ui_in[7];

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A read frees a slot this edge, so a write into a full FIFO may proceed alongside it.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  assign uo_out  = {empty, full, dout};
  assign uio_out = 8'(count);
  assign uio_oe  = 8'hFF;
  assign unused  = &{1'b0, ena, uio_in};

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_monishvr_fifo.sv
`default_nettype none
// tb_tt_um_monishvr_fifo: queue-model scoreboard with directed and random traffic.
// Revision: 1.0 - initial release
module tb_tt_um_monishvr_fifo;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_monishvr_fifo dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] model_q[$];
  logic [5:0] model_dout;
  int         tests;
  int         fails;

  // Reference: the FIFO is a queue; a read pops first, then a write pushes if room remains.
  task automatic cyc(input logic rst, input logic wr, input logic rd,
                     input logic [5:0] din, input string tag);
    bit   rd_acc;
    bit   wr_acc;
    exp_t e;
    int   n;
    rst_n = rst;
    ui_in = {rd, wr, din};
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_dout = 6'h00;
    end else begin
      rd_acc = rd && (model_q.size() > 0);
      wr_acc = wr && ((model_q.size() < 16) || rd_acc);
      if (rd_acc) model_dout = model_q.pop_front();
      if (wr_acc) model_q.push_back(din);
    end
    n     = model_q.size();
    e.uo  = {(n == 0), (n == 16), model_dout};
    e.uio = 8'(n);
    e.tag = tag;
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (uo_out !== e.uo) begin
        fails++;
        $display("FAIL %s uo_out: got %h expected %h", e.tag, uo_out, e.uo);
      end
      tests++;
      if (uio_out !== e.uio) begin
        fails++;
        $display("FAIL %s uio_out: got %h expected %h", e.tag, uio_out, e.uio);
      end
      tests++;
      if (uio_oe !== 8'hFF) begin
        fails++;
        $display("FAIL %s uio_oe: got %h expected ff", e.tag, uio_oe);
      end
    end
  end

  initial begin
    tests      = 0;
    fails      = 0;
    model_dout = 6'h00;
    ena        = 1'b1;
    uio_in     = 8'h00;
    rst_n      = 1'b1;
    ui_in      = 8'h00;
    #2;

    cyc(1, 0, 0, 6'h00, "reset");
    cyc(1, 1, 1, 6'h15, "reset_prio");

    cyc(0, 1, 0, 6'h2A, "single_wr");
    cyc(0, 0, 1, 6'h00, "single_rd");
    cyc(0, 0, 0, 6'h00, "single_idle");

    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 6'(i), "fill");
    cyc(0, 1, 0, 6'h3F, "overflow");
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 6'h00, "drain");

    // dout now holds 0x0F from the last drain read.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 6'h00, "underflow");

    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 6'(i), "fill2");
    cyc(0, 1, 1, 6'h30, "rdwr_full");
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 6'h00, "drain2");

    cyc(0, 1, 1, 6'h11, "rdwr_empty");
    cyc(0, 0, 1, 6'h00, "rd_after_rdwr");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, 6'(r * 8 + i + 3), "wrap_wr");
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 6'h00, "wrap_rd");
    end

    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 6'(i + 40), "pre_rst");
    cyc(1, 0, 0, 6'h00, "mid_reset");
    cyc(0, 0, 1, 6'h00, "rd_after_rst");
    cyc(0, 1, 1, 6'h22, "mid_rdwr");
    cyc(0, 1, 0, 6'h23, "mid_wr");
    cyc(0, 1, 1, 6'h24, "mid_rdwr2");

    for (int i = 0; i < 3000; i++) begin
      logic       wr;
      logic       rd;
      logic       rs;
      int         phase;
      phase = (i / 200) % 3;
      case (phase)
        0:       begin wr = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 3) == 0); end
        1:       begin wr = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) != 0); end
        default: begin wr = $urandom_range(0, 1) != 0;   rd = $urandom_range(0, 1) != 0;   end
      endcase
      rs = ($urandom_range(0, 399) == 0);
      cyc(rs, wr, rd, 6'($urandom), "random");
    end

    ui_in = 8'h00;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_um_monishvr_fifo.md
Name: tt_um_monishvr_fifo

Overview:
Synchronous single-clock FIFO packaged as a Tiny Tapeout user tile. Write data, write strobe and read strobe arrive on the dedicated inputs. Read data and full/empty flags leave on the dedicated outputs. The current occupancy is driven on the bidirectional pins.

Parameters:
- DATA_W, 6, FIFO word width; fixed by the pin map.
- DEPTH, 16, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1 (5), occupancy counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-high: rst_n=1 at a rising clk edge resets the block. One clock; reset is synchronous and active-high.
- ena  in  1  tile select; ignored, the design runs whenever clocked.
- ui_in  in  8  [5:0] write data (din), [6] wr_en, [7] rd_en.
- uo_out  out  8  [5:0] read data (dout), [6] full, [7] empty.
- uio_in  in  8  unused.
- uio_out  out  8  [4:0] occupancy count, [7:5] = 0.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- State:
  - Memory of DEPTH x DATA_W.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, CNT_W bits.
  - dout register.
- Reset (rst_n=1 at an edge):
  - Write pointer, read pointer, count and dout are all cleared to 0.
  - Memory contents are not cleared.
  - Result: uo_out = 8'h80 (empty=1, full=0, dout=0) and uio_out = 0.
  - Reset takes priority over wr_en and rd_en in the same cycle.
  - Reset mid-operation discards all stored data.
- Flags are combinational from count:
  - empty = (count == 0).
  - full = (count == DEPTH).
- Write accepted when wr_en=1 and (!full or read accepted this same cycle):
  - mem[wptr] <= din.
  - wptr increments.
- Read accepted when rd_en=1 and !empty:
  - dout <= mem[rptr].
  - rptr increments.
- Read latency: dout updates at the same edge that accepts the read, so it is visible one cycle after the strobe is sampled. dout holds its value when no read is accepted.
- Strobes are level-sensitive: one operation per clock while held high. No edge detection.
- count update per edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
- Boundary conditions:
  - Write when full with no read: ignored; memory, pointers and count unchanged.
  - Read when empty: ignored; dout holds.
  - Simultaneous rd and wr when empty: write accepted, read ignored, no bypass. Count becomes 1 and dout is unchanged.
  - Simultaneous rd and wr when full: both accepted, count stays DEPTH. The oldest word goes to dout and the new word occupies the freed slot.
  - Simultaneous rd and wr when 0 < count < DEPTH: both accepted, count unchanged.
  - Pointer wrap: after DEPTH writes the write pointer returns to 0, and ordering is preserved across the wrap.
- Outputs other than uo_out and uio_out[4:0] are constant.
- No X may reach uo_out after reset: dout resets to 0 and is only loaded from written locations.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles -> uo_out=8'h80, uio_out=8'h00.
- Single write then read:
  - Write 6'h2A for one cycle -> empty=0, count=1.
  - Assert rd_en for one cycle -> next cycle uo_out[5:0]=6'h2A, empty=1, count=0.
- Fill and overflow:
  - Write values 0..15 -> full=1, count=16, uo_out[7:6]=2'b01.
  - A 17th write of 6'h3F is dropped.
  - 16 reads return 0..15 in order, then empty=1.
- Underflow: on an empty FIFO with dout=6'h0F, assert rd_en for 3 cycles -> dout stays 6'h0F, count stays 0, empty=1.
- Simultaneous access:
  - Full FIFO holding 0..15, rd+wr with din=6'h30 -> dout=0, count=16, and the 16th later read returns 6'h30.
  - Empty FIFO, rd+wr with din=6'h11 -> count=1, and the next read returns 6'h11.
- Wrap and mid-operation reset:
  - Perform 3 rounds of write-8/read-8 with distinct data -> strict FIFO order in every round.
  - Write 5 words, then pulse reset -> count=0, empty=1, and a subsequent read leaves dout=0.
